// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// Module  : fpu_pkg
// Brief   : Shared FP32 constants and tag type for the fmul issue front end.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP_INF  = 32'h7F80_0000;
  localparam int TAG_W = 5;

  typedef logic [TAG_W-1:0] tag_t;

endpackage

`default_nettype wire

// File: rtl/fmul_issue_queue_if.sv
// ---------------------------------------------------------------------------
// Module  : fmul_issue_queue_if
// Brief   : Operand intake, multiplier and result-drain signals of the queue.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fmul_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      mul_x1;
  logic [31:0]      mul_x2;
  logic [31:0]      mul_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_x1, in_x2, in_tag, mul_y, out_ready,
    output in_ready, mul_x1, mul_x2, out_valid, out_y, out_tag, count
  );

  modport master (
    output in_valid, in_x1, in_x2, in_tag, mul_y, out_ready,
    input  in_ready, mul_x1, mul_x2, out_valid, out_y, out_tag, count
  );

endinterface

`default_nettype wire

// File: rtl/fpu_sync_fifo.sv
// ---------------------------------------------------------------------------
// Module  : fpu_sync_fifo
// Brief   : Synchronous FIFO with extra-bit pointers; occupancy is the diff.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en_i};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/fmul_issue_queue.sv
// ---------------------------------------------------------------------------
// Module  : fmul_issue_queue
// Brief   : Credit-issued front end and result FIFO for a non-stallable fmul.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fmul_issue_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int LAT   = 3
) (
  input  logic                clk,
  input  logic                rst,
  fmul_issue_queue_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FW    = FP32_W + TAG_W;

  logic              acc;
  logic              pop;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  count;
  logic [FW-1:0]     head;
  logic [LAT-1:0]    vpipe_q;
  logic [TAG_W-1:0]  tpipe_q [LAT];
  logic [FP32_W-1:0] mul_x1_q, mul_x2_q;

  // Every in-flight op already owns a FIFO slot, so the multiplier never overruns it.
  assign in_ready  = (int'(count) + $countones(vpipe_q)) < DEPTH;
  assign acc       = bus.in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x1_q <= FP_ZERO;
      mul_x2_q <= FP_ZERO;
      vpipe_q  <= '0;
      for (int i = 0; i < LAT; i++) begin
        tpipe_q[i] <= '0;
      end
    end else begin
      if (acc) begin
        mul_x1_q <= bus.in_x1;
        mul_x2_q <= bus.in_x2;
      end
      vpipe_q    <= {vpipe_q[LAT-2:0], acc};
      tpipe_q[0] <= acc ? bus.in_tag : '0;
      for (int i = 1; i < LAT; i++) begin
        tpipe_q[i] <= tpipe_q[i-1];
      end
    end
  end

  fpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (vpipe_q[LAT-1]),
    .wr_data_i ({bus.mul_y, tpipe_q[LAT-1]}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.mul_x1    = mul_x1_q;
  assign bus.mul_x2    = mul_x2_q;
  assign bus.out_valid = out_valid;
  assign bus.count     = count;
  assign bus.out_y     = out_valid ? head[FW-1:TAG_W] : FP_ZERO;
  assign bus.out_tag   = out_valid ? head[TAG_W-1:0]  : '0;

endmodule

`default_nettype wire

// File: tb/tb_fmul_issue_queue.sv
// ---------------------------------------------------------------------------
// Module  : tb_fmul_issue_queue
// Brief   : Directed bench with a queue-level reference model of the issue queue.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fmul_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int LAT   = 3;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               due;
  } fl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmul_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  fmul_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Stand-in multiplier: known pairs give true IEEE products, others a fixed mix.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'h7F000000_7F000000: return 32'h7F800000;
      64'h00000000_C0000000: return 32'h80000000;
      default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
    endcase
  endfunction

  logic [31:0] m_s1;
  always @(posedge clk) begin
    m_s1      <= fmul_ref(bus.mul_x1, bus.mul_x2);
    bus.mul_y <= m_s1;
  end

  // Reference model: results in flight with their landing edge, and the queue.
  fl_t  infl[$];
  res_t mq[$];
  res_t log_q[$];
  int   ec = 0;

  always @(posedge rst) begin
    infl.delete();
    mq.delete();
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic logic exp_ready = (mq.size() + infl.size()) < DEPTH;
      automatic logic acc, pop;
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_y", bus.out_y, mq[0].y);
        chk("out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
      end else begin
        chk("out_y_empty", bus.out_y, 32'h0);
        chk("out_tag_empty", 32'(bus.out_tag), 32'h0);
      end
      if (bus.out_valid && bus.out_ready) log_q.push_back('{bus.out_y, bus.out_tag});
      acc = bus.in_valid && exp_ready;
      pop = (mq.size() > 0) && bus.out_ready;
      if (pop) void'(mq.pop_front());
      while (infl.size() > 0 && infl[0].due == ec + 1) begin
        chk("no_write_into_full", 32'(mq.size() < DEPTH), 32'h1);
        mq.push_back('{infl[0].y, infl[0].tag});
        void'(infl.pop_front());
      end
      if (acc) infl.push_back('{fmul_ref(bus.in_x1, bus.in_x2), bus.in_tag, ec + 1 + LAT});
      ec++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    logic r;
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x1 = a;
    bus.in_x2 = b;
    bus.in_tag = t;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      done = r;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'h0, 32'h1);
  endtask

  int op_i;
  int n_acc;

  task automatic load_op(input int nops, input int tagbase);
    bus.in_valid = (op_i < nops);
    bus.in_x1 = 32'h1000_0000 + 32'(op_i * 7 + tagbase);
    bus.in_x2 = 32'h2345_0000 + 32'(op_i * 13);
    bus.in_tag = TAG_W'(tagbase + op_i);
  endtask

  task automatic offer_cycle(input int nops, input int tagbase);
    logic r;
    @(negedge clk);
    r = bus.in_ready && bus.in_valid;
    @(posedge clk);
    #1;
    if (r) begin
      n_acc++;
      op_i++;
      load_op(nops, tagbase);
    end
  endtask

  task automatic check_stream(input int nops, input int tagbase, input string name);
    chk({name, "_len"}, 32'(log_q.size()), 32'(nops));
    for (int k = 0; k < nops && k < log_q.size(); k++) begin
      chk({name, "_tag"}, 32'(log_q[k].tag), 32'(TAG_W'(tagbase + k)));
      chk({name, "_y"}, log_q[k].y,
          fmul_ref(32'h1000_0000 + 32'(k * 7 + tagbase), 32'h2345_0000 + 32'(k * 13)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_x1 = '0;
    bus.in_x2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_y", bus.out_y, 32'h0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'h0);
    chk("rst_mul_x1", bus.mul_x1, 32'h0);
    chk("rst_mul_x2", bus.mul_x2, 32'h0);
    #10 rst = 1'b0;
    step(1);

    // Single op: visible after the third edge following acceptance, gone after the fourth.
    bus.out_ready = 1'b1;
    send(32'h40000000, 32'h40400000, 5'd3);
    chk("mul_x1_loaded", bus.mul_x1, 32'h40000000);
    step(1); chk("t1_ov_e1", 32'(bus.out_valid), 32'h0);
    step(1); chk("t1_ov_e2", 32'(bus.out_valid), 32'h0);
    step(1); chk("t1_ov_e3", 32'(bus.out_valid), 32'h1);
    chk("t1_y", bus.out_y, 32'h40C00000);
    chk("t1_tag", 32'(bus.out_tag), 32'h3);
    step(1); chk("t1_ov_e4", 32'(bus.out_valid), 32'h0);

    // Back-to-back stream.
    log_q.delete();
    send(32'h3FC00000, 32'h3FC00000, 5'd1);
    send(32'h7F000000, 32'h7F000000, 5'd2);
    send(32'h00000000, 32'hC0000000, 5'd3);
    step(6);
    chk("t2_len", 32'(log_q.size()), 32'h3);
    if (log_q.size() == 3) begin
      chk("t2_y0", log_q[0].y, 32'h40100000); chk("t2_tag0", 32'(log_q[0].tag), 32'h1);
      chk("t2_y1", log_q[1].y, 32'h7F800000); chk("t2_tag1", 32'(log_q[1].tag), 32'h2);
      chk("t2_y2", log_q[2].y, 32'h80000000); chk("t2_tag2", 32'(log_q[2].tag), 32'h3);
    end

    // Backpressure, then drain from full.
    log_q.delete();
    bus.out_ready = 1'b0;
    op_i = 0; n_acc = 0;
    load_op(6, 10);
    repeat (10) offer_cycle(6, 10);
    chk("t3_accepts", 32'(n_acc), 32'h4);
    chk("t3_count_full", 32'(bus.count), 32'h4);
    chk("t3_ready_low", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    offer_cycle(6, 10);
    chk("t4_ready_after_pop", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 100 && (op_i < 6 || log_q.size() < 6); k++) offer_cycle(6, 10);
    check_stream(6, 10, "t3");

    // Asynchronous reset with two ops in flight.
    log_q.delete();
    send(32'h40000000, 32'h40400000, 5'd7);
    send(32'h3FC00000, 32'h3FC00000, 5'd8);
    #1 rst = 1'b1;
    #1;
    chk("t5_in_ready", 32'(bus.in_ready), 32'h1);
    chk("t5_count", 32'(bus.count), 32'h0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_mul_x1", bus.mul_x1, 32'h0);
    #1 rst = 1'b0;
    step(6);
    chk("t5_no_result", 32'(log_q.size()), 32'h0);
    send(32'h40000000, 32'h40400000, 5'd9);
    step(6);
    chk("t5_len", 32'(log_q.size()), 32'h1);
    if (log_q.size() == 1) begin
      chk("t5_y", log_q[0].y, 32'h40C00000);
      chk("t5_tag", 32'(log_q[0].tag), 32'h9);
    end

    // Wrap-around with random backpressure.
    log_q.delete();
    op_i = 0; n_acc = 0;
    load_op(3 * DEPTH + 1, 2);
    for (int k = 0; k < 500 && (op_i < 3 * DEPTH + 1 || log_q.size() < 3 * DEPTH + 1); k++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      offer_cycle(3 * DEPTH + 1, 2);
    end
    bus.out_ready = 1'b1;
    step(2);
    check_stream(3 * DEPTH + 1, 2, "t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
